// File: rtl/fsm_control_proceso_param_pkg.sv
// Shared definitions for the process-start controller: state encoding,
// button indices and width helpers used to size counters and the selector.
package fsm_control_proceso_param_pkg;

  // State encoding is visible on the estado debug port, so values are fixed.
  typedef enum logic [1:0] {
    E_INICIO   = 2'd0,
    E_ARRANQUE = 2'd1,
    E_PROCESO  = 2'd2,
    E_ESPERA   = 2'd3
  } estado_e;

  // Button slots in the debouncer bank.
  localparam int NUM_BOTONES = 3;
  localparam int B_INICIO    = 0;
  localparam int B_FIN       = 1;
  localparam int B_MODO      = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Width of an index that can address n items, never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Width of the filter selector for a given filter count.
  function automatic int sel_width(input int n_filtros);
    return idx_width(n_filtros);
  endfunction

endpackage

// File: rtl/fsm_control_proceso_param_if.sv
// Button / datapath-control bundle between the board-facing environment
// (master) and the process-start controller (slave).
interface fsm_control_proceso_param_if #(
  parameter int SEL_W = 2
);
  import fsm_control_proceso_param_pkg::*;

  logic             boton_inicio;
  logic             boton_fin;
  logic             boton_modo;
  logic             proceso_listo;
  logic             iniciar;
  logic             abortar;
  logic             ocupado;
  logic [SEL_W-1:0] filtro_sel;
  logic             timeout;
  estado_e          estado;

  modport master (
    output boton_inicio, boton_fin, boton_modo, proceso_listo,
    input  iniciar, abortar, ocupado, filtro_sel, timeout, estado
  );

  modport slave (
    input  boton_inicio, boton_fin, boton_modo, proceso_listo,
    output iniciar, abortar, ocupado, filtro_sel, timeout, estado
  );

endinterface

// File: rtl/fsm_control_proceso_param_antirrebote.sv
// Single-button debouncer: 2-FF synchroniser, run-length counter that flips
// the stable level after DEB_CYCLES consecutive differing samples, and a
// one-cycle rising-edge strobe on the stable level.
module fsm_control_proceso_param_antirrebote
  import fsm_control_proceso_param_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  output logic estable,
  output logic flanco
);

  localparam int                CNT_W    = idx_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             estable_q, estable_d;
  logic             previo_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the stable level; any
  // agreeing sample restarts the run, so short glitches never flip it.
  always_comb begin
    cnt_d     = cnt_q;
    estable_d = estable_q;
    if (sync2_q == estable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      estable_d = sync2_q;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, counter, stable level and its one-cycle-delayed copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      estable_q <= 1'b0;
      previo_q  <= 1'b0;
    end else begin
      sync1_q   <= in_raw;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      estable_q <= estable_d;
      previo_q  <= estable_q;
    end
  end

  assign estable = estable_q;
  assign flanco  = estable_q & ~previo_q;

endmodule

// File: rtl/fsm_control_proceso_param.sv
// Process-start controller: debounces start/abort/mode buttons, lets the user
// pick a filter while idle, pulses the datapath start, then supervises the run
// until done, user abort or watchdog expiry, and re-arms once all buttons
// are released.
module fsm_control_proceso_param
  import fsm_control_proceso_param_pkg::*;
#(
  parameter int DEB_CYCLES     = 16,
  parameter int N_FILTROS      = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         reset,
  fsm_control_proceso_param_if.slave   bus
);

  localparam int               SEL_W   = sel_width(N_FILTROS);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_FILTROS - 1);
  // Watchdog counter only needs to reach TIMEOUT_CYCLES-1; a zero limit
  // disables the expiry compare entirely.
  localparam int               WD_W    = idx_width(TIMEOUT_CYCLES + 1);
  localparam int               WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit               WD_EN   = (TIMEOUT_CYCLES != 0);

  logic [NUM_BOTONES-1:0] boton_raw;
  logic [NUM_BOTONES-1:0] estable;
  logic [NUM_BOTONES-1:0] flanco;

  estado_e          estado_q, estado_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             abortar_q, abortar_d;
  logic             timeout_q, timeout_d;
  logic             wd_expira;
  logic             todos_sueltos;

  assign boton_raw[B_INICIO] = bus.boton_inicio;
  assign boton_raw[B_FIN]    = bus.boton_fin;
  assign boton_raw[B_MODO]   = bus.boton_modo;

  // One debouncer per physical button.
  generate
    for (genvar gi = 0; gi < NUM_BOTONES; gi++) begin : g_antirrebote
      fsm_control_proceso_param_antirrebote #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_antirrebote (
        .clk     (clk),
        .reset   (reset),
        .in_raw  (boton_raw[gi]),
        .estable (estable[gi]),
        .flanco  (flanco[gi])
      );
    end
  endgenerate

  assign wd_expira     = WD_EN && (wd_q == WD_W'(WD_LAST));
  assign todos_sueltos = ~|estable;

  // Next-state logic; selector, watchdog, timeout flag and abort pulse are
  // all decided here so they stay consistent with the transition taken.
  always_comb begin
    estado_d  = estado_q;
    sel_d     = sel_q;
    wd_d      = wd_q;
    abortar_d = 1'b0;
    timeout_d = timeout_q;
    case (estado_q)
      E_INICIO: begin
        // Start has priority over a coincident mode press.
        if (flanco[B_INICIO]) begin
          estado_d = E_ARRANQUE;
        end else if (flanco[B_MODO]) begin
          sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
        end
      end
      E_ARRANQUE: begin
        estado_d  = E_PROCESO;
        timeout_d = 1'b0;
        wd_d      = '0;
      end
      E_PROCESO: begin
        wd_d = wd_q + WD_W'(1);
        if (bus.proceso_listo) begin
          estado_d = E_ESPERA;
        end else if (flanco[B_FIN]) begin
          estado_d  = E_ESPERA;
          abortar_d = 1'b1;
        end else if (wd_expira) begin
          estado_d  = E_ESPERA;
          abortar_d = 1'b1;
          timeout_d = 1'b1;
        end
      end
      E_ESPERA: begin
        // Holding any button keeps us here, so a held start cannot retrigger.
        if (todos_sueltos) estado_d = E_INICIO;
      end
      default: estado_d = E_INICIO;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= E_INICIO;
      sel_q     <= '0;
      wd_q      <= '0;
      abortar_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      sel_q     <= sel_d;
      wd_q      <= wd_d;
      abortar_q <= abortar_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.iniciar    = (estado_q == E_ARRANQUE);
  assign bus.ocupado    = (estado_q == E_ARRANQUE) || (estado_q == E_PROCESO);
  assign bus.abortar    = abortar_q;
  assign bus.timeout    = timeout_q;
  assign bus.filtro_sel = sel_q;
  assign bus.estado     = estado_q;

endmodule

// File: doc/fsm_control_proceso_param.md
Name: fsm_control_proceso_param

Overview:
Parametrised successor to the single-shot process-start FSM. It debounces three push-buttons, lets the user select one of N_FILTROS filters, and issues a one-cycle start pulse to the filter datapath. It tracks the busy phase until the datapath reports done, the user aborts, or a watchdog expires, then waits for all buttons to be released before re-arming. It sits between board buttons and the filter core control inputs.

Parameters:
DEB_CYCLES, 16, consecutive cycles a synchronised button must differ from its stable value before the stable value flips (>=1)
N_FILTROS, 4, number of selectable filters (>=2)
TIMEOUT_CYCLES, 1000000, watchdog limit in E_PROCESO; 0 disables the watchdog

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
boton_inicio  in  1  raw start button, asynchronous to clk
boton_fin  in  1  raw abort button, asynchronous
boton_modo  in  1  raw filter-select button, asynchronous
proceso_listo  in  1  done strobe from datapath, synchronous to clk
iniciar  out  1  one-cycle start pulse to datapath
abortar  out  1  one-cycle abort pulse to datapath
ocupado  out  1  high while in E_ARRANQUE or E_PROCESO
filtro_sel  out  max(1,$clog2(N_FILTROS))  selected filter index
timeout  out  1  sticky watchdog flag
estado  out  2  current state encoding, for debug

Behaviour:
- Reset (synchronous, active-high): state E_INICIO; iniciar, abortar, ocupado, timeout = 0; filtro_sel = 0; debouncer stable values, synchronisers and all counters = 0. Reset mid-process gives no abortar pulse.
- Debounce, per button:
  - 2-FF synchroniser feeds a counter.
  - The counter clears whenever the synchronised value equals the stable value.
  - Stable flips when the synchronised value has differed for DEB_CYCLES consecutive cycles.
  - A raw level held constant appears on stable exactly 2+DEB_CYCLES clocks later. Glitches shorter than DEB_CYCLES are ignored.
  - Edge strobe = stable & ~stable_prev, high for exactly one cycle.
- State encoding: E_INICIO=0, E_ARRANQUE=1, E_PROCESO=2, E_ESPERA=3. Registered state, Moore outputs.
- E_INICIO:
  - inicio edge -> E_ARRANQUE.
  - Otherwise, modo edge -> filtro_sel increments, wrapping N_FILTROS-1 -> 0.
  - If inicio and modo edges coincide, start wins and filtro_sel is unchanged.
  - fin edge and proceso_listo are ignored.
- E_ARRANQUE: iniciar=1 for this single cycle. Clears timeout and the watchdog counter. Unconditionally -> E_PROCESO; proceso_listo is ignored here.
- E_PROCESO:
  - Watchdog counter increments each cycle starting from 0.
  - Exit priority: proceso_listo > fin edge > watchdog (counter == TIMEOUT_CYCLES-1, only when TIMEOUT_CYCLES != 0).
  - proceso_listo -> E_ESPERA, no abortar.
  - fin edge -> abortar pulse, then E_ESPERA.
  - Watchdog -> abortar pulse, timeout set, then E_ESPERA.
  - abortar is registered and is high in the first E_ESPERA cycle only.
  - inicio and modo edges are ignored.
- E_ESPERA: -> E_INICIO when all three stable values are 0, otherwise hold. A start button held through the run never retriggers.
- Latency: the inicio edge is on cycle t, so iniciar is high on t+1 and ocupado is high from t+1.
- filtro_sel changes only in E_INICIO and is constant from E_ARRANQUE through E_ESPERA.
- timeout stays set until the next E_ARRANQUE or reset.

Decomposition:
- Shared package/include: state localparams E_*, the SEL_W width expression, and a clog2 helper function.
- Sub-module antirrebote, parameter DEB_CYCLES, ports clk, reset, in_raw, estable, flanco. Instantiated three times.

Test Plan:
(Bench parameters: DEB_CYCLES=4, N_FILTROS=3, TIMEOUT_CYCLES=20.)
- Press boton_inicio at cycle 10 and hold -> stable at 16, iniciar high only at 17, ocupado high from 17; proceso_listo at 25 -> ocupado low at 26; release the button -> E_INICIO 7 cycles after the release.
- Three-cycle glitch on boton_modo -> filtro_sel unchanged. Four clean modo presses -> filtro_sel 1, 2, 0, 1.
- Start, then no proceso_listo -> abortar one-cycle pulse and timeout=1 exactly 20 cycles after entering E_PROCESO. Next start clears timeout.
- boton_fin press during E_PROCESO -> single abortar pulse, timeout=0. proceso_listo and fin edge on the same cycle -> done path taken, no abortar.
- Simultaneous inicio and modo edges in E_INICIO -> iniciar fires and filtro_sel is unchanged. modo presses while ocupado -> filtro_sel unchanged.
- reset asserted mid-E_PROCESO -> next cycle state=0, all outputs 0, no abortar. proceso_listo pulsed in E_INICIO -> no effect.
